alu_writeback_stage: RTL

//  Downstream neighbour of the registered ALU: accepts ALU results plus Z/V flags over valid/ready,

---
 rtl/neocore_pkg.sv | 34 +++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/alu_writeback_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/neocore_pkg.sv
// ============================================================================
//  Module      : neocore_pkg
//  Description : Shared types for the ALU writeback stage: FSM state encoding
//                and the packed queue entry carrying one ALU result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neocore_pkg;

   // Register address width carried inside a queue entry
   localparam int ENTRY_ADDR_W = 4;
   // Register-file data width; a wide result is two of these
   localparam int RF_DATA_W    = 16;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_LO   = 2'd1,
      WB_HI   = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [2*RF_DATA_W-1:0]  result;
      logic                    z;
      logic                    v;
      logic [ENTRY_ADDR_W-1:0] rd;
      logic [ENTRY_ADDR_W-1:0] rd2;
      logic                    wide;
      logic                    flags_en;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO of wb_entry_t. Pointers carry an extra wrap
//                bit so full and empty fall out of a single pointer compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
   import neocore_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W = IDX_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Same index, different wrap bit means the write pointer lapped the read pointer
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   // A simultaneous pop frees the slot, so a push is legal even when full
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[IDX_W-1:0]];

   // Pointer update; storage itself needs no reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Entry storage write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/alu_writeback_stage.sv
// ============================================================================
//  Module      : alu_writeback_stage
//  Description : Queues ALU results and retires them into the register file
//                through one write port (wide results as low then high half).
//                Owns the Z/V flag register, the forwarding tap and the
//                retired-operation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_writeback_stage
   import neocore_pkg::*;
#(
   parameter int REG_COUNT  = 16,
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_result,
   input  logic              ex_z,
   input  logic              ex_v,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [ADDR_W-1:0] ex_rd2,
   input  logic              ex_wide,
   input  logic              ex_flags_en,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [15:0]       rf_wdata,
   output logic              z_flag_q,
   output logic              v_flag_q,
   output logic              fwd_valid,
   output logic              busy,
   output logic [15:0]       retire_count
);

   // Queue entries carry register addresses at a fixed width
   if (ADDR_W != $clog2(REG_COUNT) || ADDR_W != ENTRY_ADDR_W) begin : g_bad_params
      $error("alu_writeback_stage: ADDR_W must equal clog2(REG_COUNT) and ENTRY_ADDR_W");
   end

   wb_state_e   state_q;
   wb_state_e   state_d;
   wb_entry_t   hold_q;
   wb_entry_t   q_head;
   wb_entry_t   push_entry;
   logic        q_full;
   logic        q_empty;
   logic        q_push;
   logic        q_pop;
   logic        final_wr;
   logic        flag_ld;
   logic [15:0] retire_count_q;

   assign ex_ready = !q_full;
   assign q_push   = ex_valid && ex_ready;

   assign push_entry.result   = ex_result;
   assign push_entry.z        = ex_z;
   assign push_entry.v        = ex_v;
   assign push_entry.rd       = ex_rd;
   assign push_entry.rd2      = ex_rd2;
   assign push_entry.wide     = ex_wide;
   assign push_entry.flags_en = ex_flags_en;

   wb_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (push_entry),
      .pop       (q_pop),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   // Next state, queue pop and register-file write port driven from the held entry
   always_comb begin
      state_d  = state_q;
      q_pop    = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      final_wr = 1'b0;
      flag_ld  = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (!q_empty) begin
               q_pop   = 1'b1;
               state_d = WB_LO;
            end
         end
         WB_LO: begin
            rf_we    = 1'b1;
            rf_waddr = hold_q.rd;
            rf_wdata = hold_q.result[15:0];
            flag_ld  = hold_q.flags_en;
            if (hold_q.wide) begin
               state_d = WB_HI;
            end else begin
               final_wr = 1'b1;
               if (!q_empty) begin
                  q_pop   = 1'b1;
                  state_d = WB_LO;
               end else begin
                  state_d = WB_IDLE;
               end
            end
         end
         WB_HI: begin
            rf_we    = 1'b1;
            rf_waddr = hold_q.rd2;
            rf_wdata = hold_q.result[31:16];
            final_wr = 1'b1;
            if (!q_empty) begin
               q_pop   = 1'b1;
               state_d = WB_LO;
            end else begin
               state_d = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // State register and holding register, loaded from the queue head on pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WB_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         if (q_pop) hold_q <= q_head;
      end
   end

   // Architectural flags (copied verbatim from the ALU) and retired-op counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_flag_q       <= 1'b0;
         v_flag_q       <= 1'b0;
         retire_count_q <= '0;
      end else begin
         if (flag_ld) begin
            z_flag_q <= hold_q.z;
            v_flag_q <= hold_q.v;
         end
         if (final_wr) retire_count_q <= retire_count_q + 16'd1;
      end
   end

   assign retire_count = retire_count_q;
   assign fwd_valid    = rf_we;
   assign busy         = !q_empty || (state_q != WB_IDLE);

endmodule

`default_nettype wire
